// File: rtl/gate_vector_checker_pkg.sv
// ---------------------------------------------------------------------------
// gate_vector_checker_pkg
//   Shared definitions for the 2-input gate truth-table checker:
//     - op_e    : gate select encodings (AND..XNOR); codes 6 and 7 are reserved
//     - state_e : checker FSM states (3-bit)
//     - small helpers used by the top and the reference model
// ---------------------------------------------------------------------------
package gate_vector_checker_pkg;

    // Gate select codes presented on the op port.
    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5
    } op_e;

    // Checker FSM states.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    // Settle counter width; covers the legal SETTLE_CYCLES range 1..15.
    localparam int SETTLE_CNT_W = 4;

    // Index of the last of the four input vectors (A,B = 1,1).
    localparam logic [1:0] LAST_VEC = 2'd3;

    // True for the reserved gate codes 6 and 7.
    function automatic logic is_reserved_op(input logic [2:0] op);
        return (op > 3'd5);
    endfunction

endpackage

// File: rtl/gate_vector_checker_gate_ref_model.sv
// ---------------------------------------------------------------------------
// gate_ref_model
//   Combinational golden model of the selectable 2-input gate.
//   Ports:
//     op_i    in  3  gate select (gate_vector_checker_pkg::op_e encodings)
//     a_i     in  1  gate input A
//     b_i     in  1  gate input B
//     exp_o   out 1  expected gate output
//     valid_o out 1  0 for reserved ops (6, 7); exp_o is then meaningless
// ---------------------------------------------------------------------------
module gate_ref_model
    import gate_vector_checker_pkg::*;
(
    input  logic [2:0] op_i,
    input  logic       a_i,
    input  logic       b_i,
    output logic       exp_o,
    output logic       valid_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        exp_o   = 1'b0;
        valid_o = !is_reserved_op(op_i);
        case (op_i)
            OP_AND:  exp_o = a_i & b_i;
            OP_OR:   exp_o = a_i | b_i;
            OP_NAND: exp_o = ~(a_i & b_i);
            OP_NOR:  exp_o = ~(a_i | b_i);
            OP_XOR:  exp_o = a_i ^ b_i;
            OP_XNOR: exp_o = ~(a_i ^ b_i);
            default: exp_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_vector_checker.sv
// ---------------------------------------------------------------------------
// gate_vector_checker
//   Self-running truth-table stage for a 2-input gate. Drives the gate inputs
//   A/B through 00,01,10,11, waits SETTLE_CYCLES per vector, samples the gate
//   output F and compares it with gate_ref_model. Reports the mismatch count
//   and pass/done status.
//
//   Parameters:
//     SETTLE_CYCLES  cycles spent in SETTLE before F is sampled (1..15)
//     ERR_W          width of err_count (>= 3 so it can hold 4)
//
//   Ports:
//     clk        in   1      rising-edge clock
//     rst        in   1      asynchronous active-high reset
//     start      in   1      begin a run; honoured only in IDLE or DONE
//     op         in   3      gate select (0 AND .. 5 XNOR, 6-7 reserved)
//     A          out  1      gate input A = vector index bit 1
//     B          out  1      gate input B = vector index bit 0
//     F          in   1      gate output under test
//     busy       out  1      high in DRIVE/SETTLE/SAMPLE
//     done       out  1      high in DONE until the next start
//     pass       out  1      with done: 1 when err_count == 0
//     err_count  out  ERR_W  mismatches in the current or last run (saturating)
//     vec_idx    out  2      current vector index
//     fail_mask  out  4      (GATE_CHK_FAIL_MASK_EN only) bit i = vector i mismatched
//
//   Optional feature macro: GATE_CHK_FAIL_MASK_EN adds the fail_mask output.
//
//   Timing: start edge -> done high after 4*(2+SETTLE_CYCLES) cycles.
// ---------------------------------------------------------------------------
module gate_vector_checker
    import gate_vector_checker_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    output logic             A,
    output logic             B,
    input  logic             F,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
`ifdef GATE_CHK_FAIL_MASK_EN
    output logic [1:0]       vec_idx,
    output logic [3:0]       fail_mask
`else
    output logic [1:0]       vec_idx
`endif
);

    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

    state_e                  state_q;
    logic [2:0]              op_q;
    logic [SETTLE_CNT_W-1:0] settle_cnt_q;
    logic [1:0]              vec_idx_q;
    logic [ERR_W-1:0]        err_count_q;
    logic [ERR_W-1:0]        err_count_d;
    logic                    a_q;
    logic                    b_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    pass_q;
    logic [1:0]              vec_idx_d;

    logic                    exp_f;
    logic                    exp_valid;
    logic                    mismatch;

`ifdef GATE_CHK_FAIL_MASK_EN
    logic [3:0]              fail_mask_q;
`endif

    // Reference model sees the registered A/B actually presented to the gate.
    gate_ref_model u_ref (
        .op_i    (op_q),
        .a_i     (a_q),
        .b_i     (b_q),
        .exp_o   (exp_f),
        .valid_o (exp_valid)
    );

    // Reserved ops have no defined answer, so every sample of them counts as a miss.
    assign mismatch = !exp_valid || (F != exp_f);

    // Saturating increment; only applied on the SAMPLE edge.
    assign err_count_d = (mismatch && (err_count_q != {ERR_W{1'b1}}))
                       ? err_count_q + 1'b1 : err_count_q;

    assign vec_idx_d = vec_idx_q + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= 3'd0;
            settle_cnt_q <= '0;
            vec_idx_q    <= 2'd0;
            err_count_q  <= '0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
`ifdef GATE_CHK_FAIL_MASK_EN
            fail_mask_q  <= 4'd0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q     <= S_DRIVE;
                        op_q        <= op;
                        err_count_q <= '0;
                        vec_idx_q   <= 2'd0;
                        a_q         <= 1'b0;
                        b_q         <= 1'b0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
`ifdef GATE_CHK_FAIL_MASK_EN
                        fail_mask_q <= 4'd0;
`endif
                    end
                end

                S_DRIVE: begin
                    state_q      <= S_SETTLE;
                    settle_cnt_q <= '0;
                end

                S_SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_q <= S_SAMPLE;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 1'b1;
                    end
                end

                S_SAMPLE: begin
                    err_count_q <= err_count_d;
`ifdef GATE_CHK_FAIL_MASK_EN
                    if (mismatch) begin
                        fail_mask_q[vec_idx_q] <= 1'b1;
                    end
`endif
                    if (vec_idx_q == LAST_VEC) begin
                        // A/B and vec_idx hold the last vector through DONE.
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_count_d == '0);
                    end else begin
                        // A/B change only on entry to DRIVE.
                        state_q   <= S_DRIVE;
                        vec_idx_q <= vec_idx_d;
                        a_q       <= vec_idx_d[1];
                        b_q       <= vec_idx_d[0];
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign vec_idx   = vec_idx_q;
`ifdef GATE_CHK_FAIL_MASK_EN
    assign fail_mask = fail_mask_q;
`endif

endmodule

// File: tb/tb_gate_vector_checker.sv
// ---------------------------------------------------------------------------
// tb_gate_vector_checker
//   Directed bench for gate_vector_checker. A behavioural gate (selectable
//   truth table, or F forced to a constant) closes the loop A/B -> F.
//   Honours GATE_CHK_FAIL_MASK_EN for the optional fail_mask output.
// ---------------------------------------------------------------------------
module tb_gate_vector_checker;

    localparam int SETTLE     = 2;
    localparam int ERR_W      = 3;
    localparam int VEC_CYC    = 2 + SETTLE;
    localparam int RUN_CYCLES = 4 * VEC_CYC;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [2:0]       op;
    logic             A;
    logic             B;
    logic             F;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       vec_idx;
`ifdef GATE_CHK_FAIL_MASK_EN
    logic [3:0]       fail_mask;
`endif

    int checks   = 0;
    int failures = 0;

    // Behavioural gate on the checker's A/B.
    int   gate_sel;
    logic force_en;
    logic force_val;
    logic [3:0] tt;

    always #5 clk = ~clk;

    gate_vector_checker #(
        .SETTLE_CYCLES (SETTLE),
        .ERR_W         (ERR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .A         (A),
        .B         (B),
        .F         (F),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
`ifdef GATE_CHK_FAIL_MASK_EN
        .vec_idx   (vec_idx),
        .fail_mask (fail_mask)
`else
        .vec_idx   (vec_idx)
`endif
    );

    // Hand-written truth tables, bit index {A,B}.
    function automatic logic [3:0] truth_table(input int sel);
        case (sel)
            0:       return 4'b1000; // AND
            1:       return 4'b1110; // OR
            2:       return 4'b0111; // NAND
            3:       return 4'b0001; // NOR
            4:       return 4'b0110; // XOR
            5:       return 4'b1001; // XNOR
            default: return 4'b0000;
        endcase
    endfunction

    always_comb begin
        tt = truth_table(gate_sel);
        F  = force_en ? force_val : tt[{A, B}];
    end

    task automatic check(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".A"},    A,         0);
        check({tag, ".B"},    B,         0);
        check({tag, ".busy"}, busy,      0);
        check({tag, ".done"}, done,      0);
        check({tag, ".pass"}, pass,      0);
        check({tag, ".err"},  err_count, 0);
        check({tag, ".vec"},  vec_idx,   0);
`ifdef GATE_CHK_FAIL_MASK_EN
        check({tag, ".mask"}, fail_mask, 0);
`endif
    endtask

    // One start pulse, then walk the run. A second pulse may be injected at
    // restart_at (-1 = none). Returns the cycle count from start edge to done.
    task automatic run(input string tag, input logic [2:0] run_op,
                       input int restart_at, output int cycles);
        int cyc;
        int k;
        @(negedge clk);
        op     = run_op;
        start  = 1'b1;
        cyc    = 0;
        cycles = -1;
        while (cycles < 0) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                check({tag, ".start_err_clr"}, err_count, 0);
                check({tag, ".start_done_clr"}, done, 0);
            end
            if (cyc == restart_at)     start = 1'b1;
            if (cyc == restart_at + 1) start = 1'b0;
            // DRIVE entries at edges 0,4,8,12 from the start edge.
            if (((cyc - 1) % VEC_CYC) == 0 && ((cyc - 1) / VEC_CYC) < 4) begin
                k = (cyc - 1) / VEC_CYC;
                check($sformatf("%s.ab%0d", tag, k), {A, B}, k);
                check($sformatf("%s.vec%0d", tag, k), vec_idx, k);
                check($sformatf("%s.busy%0d", tag, k), busy, 1);
            end
            if (done) begin
                cycles = cyc - 1;
            end else if (cyc > 4 * RUN_CYCLES) begin
                check({tag, ".timeout"}, 0, 1);
                cycles = cyc;
            end
        end
    endtask

    task automatic run_and_check(input string tag, input logic [2:0] run_op,
                                 input int exp_err, input int exp_pass,
                                 input int exp_mask, input int restart_at);
        int cycles;
        run(tag, run_op, restart_at, cycles);
        check({tag, ".latency"}, cycles,    RUN_CYCLES);
        check({tag, ".err"},     err_count, exp_err);
        check({tag, ".pass"},    pass,      exp_pass);
        check({tag, ".busy"},    busy,      0);
        check({tag, ".last_ab"}, {A, B},    3);
`ifdef GATE_CHK_FAIL_MASK_EN
        check({tag, ".mask"},    fail_mask, exp_mask);
`else
        if (exp_mask < 0) check({tag, ".mask_arg"}, exp_mask, 0);
`endif
        // DONE is held while start stays low.
        repeat (3) @(negedge clk);
        check({tag, ".done_hold"}, done, 1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        op        = 3'd0;
        gate_sel  = 0;
        force_en  = 1'b0;
        force_val = 1'b0;
        #2;
        check_reset_outputs("reset_async");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle");

        // 1. AND gate, AND op: clean pass.
        gate_sel = 0;
        run_and_check("and_ok", 3'd0, 0, 1, 4'b0000, -1);

        // 2. F tied high against AND: vectors 0..2 miss.
        force_en  = 1'b1;
        force_val = 1'b1;
        run_and_check("and_f1", 3'd0, 3, 0, 4'b0111, -1);
        force_en  = 1'b0;

        // 3. Reserved op: every sample misses.
        run_and_check("op6", 3'd6, 4, 0, 4'b1111, -1);

        // 6. XOR twice from DONE; err_count from the op6 run must clear.
        gate_sel = 4;
        run_and_check("xor_a", 3'd4, 0, 1, 4'b0000, -1);
        run_and_check("xor_b", 3'd4, 0, 1, 4'b0000, -1);

        // 5. start re-pulsed mid-run is ignored.
        gate_sel = 1;
        run_and_check("or_restart", 3'd1, 0, 1, 4'b0000, 5);

        // 4. Reset at cycle 7 of a failing run, then a full clean run.
        gate_sel  = 2;
        force_en  = 1'b1;
        force_val = 1'b0;
        @(negedge clk);
        op    = 3'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("midrun.busy", busy, 1);
        check("midrun.err",  err_count, 1);
        #1 rst = 1'b1;
        #1 check_reset_outputs("midrun_rst");
        @(negedge clk);
        rst      = 1'b0;
        force_en = 1'b0;
        @(negedge clk);
        check_reset_outputs("after_rst");
        run_and_check("nand_after_rst", 3'd2, 0, 1, 4'b0000, -1);

        // XNOR gate checked as NOR: mismatches at 01,10 do not occur (both 0),
        // 00 expects 1 and gets 1, 11 expects 0 but XNOR gives 1.
        gate_sel = 5;
        run_and_check("xnor_as_nor", 3'd3, 1, 0, 4'b1000, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
